// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sharing logic.
//   DATA_W / OP_W : default operand/result and opcode widths
//   state_t       : arbiter FSM state encoding
//   GNT_P0/GNT_P1 : grant encoding (also the alu_sel value)
package alu_pkg;

  localparam int DATA_W = 32;
  localparam int OP_W   = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic GNT_P0 = 1'b0;
  localparam logic GNT_P1 = 1'b1;

endpackage

// File: rtl/alu_req_mux.sv
// 2:1 word select between the two requester ports.
//   sel : grant (GNT_P0 selects d0, GNT_P1 selects d1)
//   d0  : word from port 0
//   d1  : word from port 1
//   y   : selected word
module alu_req_mux #(
  parameter int W = alu_pkg::DATA_W
) (
  input  logic         sel,
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  output logic [W-1:0] y
);
  import alu_pkg::*;

  assign y = (sel == GNT_P1) ? d1 : d0;

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU between two requesters (port 0: fetch/branch-target,
// port 1: execute). One operation in flight at a time, round-robin on ties.
//   req0_* / req1_*   : request channels (valid/ready, op, a, b)
//   rsp0_* / rsp1_*   : response channels (valid/ready), rsp_data shared
//   alu_sel           : registered grant of the operation in flight
//   alu_start         : one-cycle launch strobe
//   alu_op/alu_a/alu_b: registered operation, held until the next grant
//   alu_done/result   : ALU completion pulse and result
module alu_share_arbiter #(
  parameter int DATA_W = alu_pkg::DATA_W,
  parameter int OP_W   = alu_pkg::OP_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [OP_W-1:0]   req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [OP_W-1:0]   req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              alu_sel,
  output logic              alu_start,
  output logic [OP_W-1:0]   alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic              alu_done,
  input  logic [DATA_W-1:0] alu_result
);
  import alu_pkg::*;

  state_t            state, state_nxt;
  logic              last_grant;
  logic              winner;
  logic              grant;
  logic              done_take;
  logic              rsp_take;
  logic [OP_W-1:0]   op_mux;
  logic [DATA_W-1:0] a_mux, b_mux;

  // alu_done in the launch cycle belongs to no operation we can trust yet.
  assign done_take = (state == ST_BUSY) && alu_done && !alu_start;
  assign rsp_take  = (rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready);

  // NOTE: every combinational output gets a default first so no path
  // through the block leaves it unassigned and infers a latch.
  always_comb begin
    winner     = GNT_P0;
    grant      = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    state_nxt  = state;
    if (req0_valid && req1_valid) begin
      winner = ~last_grant;
    end else if (req1_valid) begin
      winner = GNT_P1;
    end
    unique case (state)
      ST_IDLE: begin
        grant      = req0_valid || req1_valid;
        req0_ready = grant && (winner == GNT_P0);
        req1_ready = grant && (winner == GNT_P1);
        if (grant) state_nxt = ST_BUSY;
      end
      ST_BUSY: if (done_take) state_nxt = ST_RESP;
      ST_RESP: if (rsp_take)  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  alu_req_mux #(.W(OP_W))   u_mux_op (.sel(winner), .d0(req0_op), .d1(req1_op), .y(op_mux));
  alu_req_mux #(.W(DATA_W)) u_mux_a  (.sel(winner), .d0(req0_a),  .d1(req1_a),  .y(a_mux));
  alu_req_mux #(.W(DATA_W)) u_mux_b  (.sel(winner), .d0(req0_b),  .d1(req1_b),  .y(b_mux));

  // last_grant resets to port 1 so port 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= GNT_P1;
      alu_sel    <= GNT_P0;
      alu_start  <= 1'b0;
      alu_op     <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      rsp_data   <= '0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
    end else begin
      alu_start <= 1'b0;
      if (grant) begin
        alu_op     <= op_mux;
        alu_a      <= a_mux;
        alu_b      <= b_mux;
        alu_sel    <= winner;
        last_grant <= winner;
        alu_start  <= 1'b1;
      end
      if (done_take) begin
        rsp_data   <= alu_result;
        rsp0_valid <= (alu_sel == GNT_P0);
        rsp1_valid <= (alu_sel == GNT_P1);
      end
      if (rsp_take) begin
        rsp0_valid <= 1'b0;
        rsp1_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Sequential arbiter that shares the single ALU between two requesters (fetch/branch-target unit on port 0, execute stage on port 1). Accepts one operation at a time via valid/ready, round-robins between the two requesters, drives the ALU operand select and start strobe, and waits for the ALU's completion. It then returns the registered result to the winning requester over a valid/ready response channel.

## Interface
- DATA_W, 32, operand/result width
- OP_W, 5, ALU opcode width
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- req0_valid / req1_valid  in  1  request present
- req0_ready / req1_ready  out  1  request accepted this cycle
- req0_op / req1_op  in  OP_W  opcode
- req0_a / req1_a  in  DATA_W  operand A
- req0_b / req1_b  in  DATA_W  operand B
- rsp0_valid / rsp1_valid  out  1  result available for that requester
- rsp0_ready / rsp1_ready  in  1  requester takes result
- rsp_data  out  DATA_W  result, shared by both response channels
- alu_sel  out  1  registered grant; 0 = port 0, 1 = port 1
- alu_start  out  1  one-cycle launch strobe
- alu_op  out  OP_W  registered opcode
- alu_a / alu_b  out  DATA_W  registered operands
- alu_done  in  1  ALU result valid (one-cycle pulse)
- alu_result  in  DATA_W  ALU output

## Operation
- States: IDLE, BUSY, RESP. Reset state IDLE.
- IDLE:
  - Winner is the only valid requester. If both are valid, the winner is the one not granted last (`last_grant`).
  - reqN_ready = 1 combinationally for the winner only; the handshake completes in that cycle.
  - On handshake: register op/a/b of the winner into alu_op/alu_a/alu_b, set alu_sel = winner, set last_grant = winner, assert alu_start for the next cycle, go to BUSY.
- BUSY:
  - alu_start is high on the first BUSY cycle only.
  - alu_done is ignored in the alu_start cycle, so minimum ALU latency is 1 cycle after start.
  - On alu_done: register alu_result into rsp_data, go to RESP.
  - No bound on wait; a hung ALU holds BUSY.
- RESP:
  - rspN_valid = 1 for N = alu_sel, held until rspN_ready. Then go to IDLE.
  - reqN_ready is 0 in BUSY and RESP.
- alu_done outside BUSY is ignored.
- rsp_ready with no matching rsp_valid is ignored.
- A requester may drop valid before being granted.
- alu_a/alu_b/alu_op/alu_sel hold their values until the next grant.

## Timing
- Reset (asynchronous, any state, including mid-operation): state = IDLE, last_grant = 1 (port 0 wins first tie). All outputs 0: alu_sel, alu_start, alu_op, alu_a, alu_b, rsp_data, rsp0_valid, rsp1_valid. The in-flight operation is abandoned with no response.
- Handshake to alu_start: 1 cycle.
- alu_done to rspN_valid: 1 cycle.
- rspN_ready to IDLE: 1 cycle, so the next grant happens at the earliest one cycle after the response handshake.
- Minimum request-to-request period: 4 cycles with a 1-cycle ALU.
- reqN_ready is a combinational function of state, last_grant and reqN_valid; there is no combinational path from alu_* or rsp*_ready to reqN_ready.
- All other outputs are registered.

## Structure
- Shared package/include `alu_pkg`:
  - DATA_W and OP_W defaults.
  - State encodings ST_IDLE = 2'd0, ST_BUSY = 2'd1, ST_RESP = 2'd2.
  - Grant constants GNT_P0 = 1'b0, GNT_P1 = 1'b1.
- One sub-module: `alu_req_mux`, a DATA_W-wide 2:1 word select.
  - Three instances, for op, a and b, selected by the combinational winner.
  - Their outputs feed the capture registers.

## Test plan
- Reset mid-BUSY: assert rst_n = 0 while BUSY -> all outputs 0 at once. Then req1 alone with op=ADD, a=5, b=7 -> req1_ready next IDLE cycle, alu_sel = 1, alu_start pulse, ALU done after 3 cycles -> rsp1_valid with rsp_data = 12.
- Tie from reset: req0 and req1 both valid -> port 0 granted first, then port 1. Four back-to-back ties alternate 0,1,0,1.
- Response backpressure: hold rsp0_ready = 0 for 5 cycles -> rsp0_valid and rsp_data are stable, and req1_ready stays 0 throughout.
- Spurious alu_done in IDLE and RESP, and alu_done in the alu_start cycle -> no state change. The result is taken only from a later alu_done.
- Requester withdraws: req0_valid pulses while BUSY then drops -> no grant to port 0; the next grant goes to req1.
- Operand hold: after a grant, change req0_a -> alu_a is unchanged until the next grant.
